// File: rtl/clkgate_pkg.sv
// Shared types and helpers for the gated-clock enable scheduler.
// Domain state encoding and counter sizing.
package clkgate_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } dom_state_t;

  function automatic int cnt_width(
    input int wake_cyc,
    input int idle_cyc
  );
    int m;
    m = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clkgate_if.sv
// Request/status bundle between requesters and the clock-enable scheduler.
// master drives requests; slave drives enables and readiness.
interface clkgate_if #(
  parameter int N_DOM = 4
);

  logic [N_DOM-1:0] dom_req;
  logic [N_DOM-1:0] dom_busy;
  logic             force_on;
  logic [N_DOM-1:0] clock_en;
  logic [N_DOM-1:0] dom_ready;
  logic             all_off;

  modport master (
    output dom_req,
    output dom_busy,
    output force_on,
    input  clock_en,
    input  dom_ready,
    input  all_off
  );

  modport slave (
    input  dom_req,
    input  dom_busy,
    input  force_on,
    output clock_en,
    output dom_ready,
    output all_off
  );

endinterface

// File: rtl/clkgate_dom_fsm.sv
// One gated domain: OFF/WAKE/ON/IDLE sequencing with settle and idle counters.
// en/rdy/is_off are true flops so the clkgate input never sees decode glitches.
module clkgate_dom_fsm
  import clkgate_pkg::*;
#(
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 4,
  parameter int CW       = cnt_width(WAKE_CYC, IDLE_CYC)
) (
  input  logic clk_in,
  input  logic rst,
  input  logic act,
  input  logic grant,
  output logic en,
  output logic rdy,
  output logic is_off,
  output logic wake_req
);

  localparam logic [CW-1:0] W_LOAD = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] I_LOAD = CW'(IDLE_CYC - 1);

  dom_state_t    state;
  dom_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      OFF: begin
        if (act && grant) begin
          state_nxt = WAKE;
          cnt_nxt   = W_LOAD;
        end
      end
      WAKE: begin
        if (cnt == '0) state_nxt = ON;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ON: begin
        if (!act) begin
          state_nxt = IDLE;
          cnt_nxt   = I_LOAD;
        end
      end
      IDLE: begin
        if (act)              state_nxt = ON;
        else if (cnt == '0)   state_nxt = OFF;
        else                  cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = OFF;
    endcase
  end

  // Outputs are registered from next-state, not decoded from state bits.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state  <= OFF;
      cnt    <= '0;
      en     <= 1'b0;
      rdy    <= 1'b0;
      is_off <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      en     <= (state_nxt != OFF);
      rdy    <= (state_nxt == ON) || (state_nxt == IDLE);
      is_off <= (state_nxt == OFF);
    end
  end

  assign wake_req = is_off & act;

endmodule

// File: rtl/clkgate_ctrl.sv
// Per-domain clock-enable scheduler with round-robin staggered wake-up.
// Requests are registered once, then arbitrated so one domain wakes per cycle.
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 4
) (
  input  logic      clk_in,
  input  logic      rst,
  clkgate_if.slave  bus
);

  localparam int CW = cnt_width(WAKE_CYC, IDLE_CYC);
  localparam int PW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  logic [N_DOM-1:0] act_q;
  logic [N_DOM-1:0] gnt;
  logic [N_DOM-1:0] en;
  logic [N_DOM-1:0] rdy;
  logic [N_DOM-1:0] is_off;
  logic [N_DOM-1:0] wake_req;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    k;
  logic             gnt_vld;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) act_q <= '0;
    else     act_q <= bus.dom_req | bus.dom_busy |
                      {N_DOM{bus.force_on}};
  end

  // First OFF-and-active domain at or after the pointer wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    k       = '0;
    for (int i = 0; i < N_DOM; i++) begin
      k = PW'((int'(rr_ptr) + i) % N_DOM);
      if (!gnt_vld && wake_req[k]) begin
        gnt_vld = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      if (gnt_idx == PW'(N_DOM - 1)) rr_ptr <= '0;
      else                           rr_ptr <= gnt_idx + 1'b1;
    end
  end

  for (genvar d = 0; d < N_DOM; d++) begin : g_dom
    clkgate_dom_fsm #(
      .WAKE_CYC (WAKE_CYC),
      .IDLE_CYC (IDLE_CYC),
      .CW       (CW)
    ) u_fsm (
      .clk_in   (clk_in),
      .rst      (rst),
      .act      (act_q[d]),
      .grant    (gnt[d]),
      .en       (en[d]),
      .rdy      (rdy[d]),
      .is_off   (is_off[d]),
      .wake_req (wake_req[d])
    );
  end

  assign bus.clock_en  = en;
  assign bus.dom_ready = rdy;
  assign bus.all_off   = &is_off;

endmodule
